mispredict_recovery_ctrl: RTL and testbench
===========================================

# mispredict_recovery_ctrl

Sequences machine-state recovery after a committed branch/jalr mispredict raised at retirement. It snapshots the committed architectural map from the RRF and flushes speculative structures. It then reloads the RAT from the snapshot, rebuilds the physical free list by walking every physical register and enqueueing those absent from the map, and finally redirects fetch. Dispatch is stalled for the whole sequence. It sits between the RRF and the ROB, RS, LSQ, RAT, free list and fetch.

## Interface
- NUM_PHYS_REG, 64, physical registers.
- NUM_ARCH_REG, 32, architectural registers.
- PREG_W, 6, physical register index width, equal to log2(NUM_PHYS_REG).

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mispredict_in  in  1  branch_mispredict from the RRF; sampled only in IDLE.
- mispredict_pc  in  32  calculated next PC of the mispredicting instruction.
- mispredict_order  in  64  order of the mispredicting instruction.
- rrf_map  in  NUM_ARCH_REG x PREG_W  committed map (RRF-to-RAT table, including same-cycle commit bypass).
- flush_out  out  1  one-cycle flush to ROB, RS, LSQ and fetch queue.
- rat_load  out  1  one-cycle pulse: RAT loads rat_restore_map.
- rat_restore_map  out  NUM_ARCH_REG x PREG_W  snapshot register contents.
- fl_clear  out  1  one-cycle pulse: free list head and tail to empty.
- fl_enq  out  1  free-list enqueue valid.
- fl_enq_preg  out  PREG_W  register being enqueued.
- fl_ready  in  1  free list accepts an enqueue this cycle.
- redirect_valid  out  1  fetch redirect valid; held until accepted.
- redirect_pc  out  32  latched mispredict_pc.
- redirect_order  out  64  latched mispredict_order.
- redirect_ready  in  1  fetch accepts the redirect.
- stall_dispatch  out  1  high in every state except IDLE.
- rebuild_err  out  1  sticky: the enqueue count was not NUM_PHYS_REG-NUM_ARCH_REG. Cleared on the next accepted mispredict.

## Operation
- The state machine has five states: IDLE, FLUSH, RESTORE, REBUILD, REDIRECT.
- In IDLE, mispredict_in is sampled high at a rising edge. On that edge the block:
  - latches pc and order;
  - copies rrf_map into the snapshot;
  - builds used[NUM_PHYS_REG], setting a bit for every physical register referenced by the snapshot;
  - clears rebuild_err, the walk index and the enqueue count;
  - moves to FLUSH.
- FLUSH lasts one cycle. flush_out=1 and fl_clear=1. Next state is RESTORE.
- RESTORE lasts one cycle. rat_load=1 and rat_restore_map holds the snapshot. Next state is REBUILD.
- REBUILD walks idx from 0 to NUM_PHYS_REG-1, one candidate per cycle.
  - If used[idx] is set: fl_enq=0 and idx advances.
  - If used[idx] is clear: fl_enq=1 and fl_enq_preg=idx. idx advances and the enqueue count increments only when fl_ready=1. Otherwise fl_enq and fl_enq_preg hold.
  - After the last idx is handled, the block compares the count against NUM_PHYS_REG-NUM_ARCH_REG. rebuild_err is set if they differ, for example when the map contains duplicates. Next state is REDIRECT.
- REDIRECT: redirect_valid=1 with the latched pc and order. When redirect_ready=1 in the same cycle, the handshake completes and the next state is IDLE.
- mispredict_in is ignored in every non-IDLE state, because the ROB has been flushed.
- rrf_map is not read after the capture edge; all later outputs come from the snapshot.
- The enqueue count is PREG_W+1 bits wide, so it cannot wrap. idx is PREG_W bits wide, and its terminal test is idx==NUM_PHYS_REG-1, never an overflow.
- fl_enq is never asserted for a used register. Physical register 0 is always mapped by x0.

## Timing
- Reset puts the state in IDLE immediately, without waiting for a clock. All outputs go to 0, including rat_restore_map, redirect_pc, redirect_order and rebuild_err. Reset mid-sequence abandons the sequence with no further pulses.
- With mispredict sampled at edge 0 and fl_ready=redirect_ready=1:
  - FLUSH occupies cycle 1 and RESTORE cycle 2.
  - REBUILD occupies cycles 3 to 3+NUM_PHYS_REG-1, which is 64 cycles at the defaults.
  - REDIRECT occupies cycle 67, and IDLE returns at cycle 68.
- Each cycle of fl_ready=0 on a pending enqueue adds one cycle. Each cycle of redirect_ready=0 adds one cycle.
- stall_dispatch rises in the cycle after the capture edge and falls the cycle after the redirect handshake.
- A mispredict on the same edge the block returns to IDLE is not captured; capture happens at the next edge where it is still high.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs, except that fl_enq stays asserted while fl_ready is low.

## Test plan
- Reset-identity map (arch i to phys i), mispredict_pc=0x1000_0040 and order=17, with both readies high:
  - flush_out and fl_clear occur at cycle 1, rat_load at cycle 2;
  - 32 enqueues of p32 to p63 occur in ascending order;
  - redirect at cycle 67 with pc 0x1000_0040 and order 17;
  - rebuild_err=0.
- Scattered map (x5 to p40, x9 to p63, others identity), fl_ready toggling 1/0:
  - enqueues are exactly p5, p9, p32 to p39 and p41 to p62;
  - each is held stable while fl_ready=0, with no duplicates.
- Duplicate map (x3 and x4 both to p4) -> 33 enqueues and rebuild_err=1. A second clean mispredict clears rebuild_err.
- redirect_ready low for 5 cycles -> redirect_valid held with a constant pc and order, stall_dispatch stays high, and IDLE is reached the cycle after the handshake.
- mispredict_in pulsed during REBUILD and rrf_map changed after capture -> no restart, and enqueues and rat_restore_map match the original snapshot.
- rst asserted asynchronously mid-REBUILD -> all outputs are 0 immediately. A mispredict after reset release runs the full sequence from idx 0.

Source files
------------

// File: rtl/mispredict_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// mispredict_recovery_ctrl
//
// Purpose:
//   Recovers machine state after a branch/jalr mispredict raised at retirement.
//   On capture it snapshots the committed architectural map and marks every
//   physical register the snapshot references. It then flushes the speculative
//   structures, reloads the RAT from the snapshot, and rebuilds the free list by
//   walking all physical registers and enqueueing each unreferenced one.
//   Finally it redirects fetch. Dispatch is stalled for the whole sequence.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   mispredict_in      mispredict request, sampled only in IDLE
//   mispredict_pc      corrected next PC, latched on capture
//   mispredict_order   order of the mispredicting instruction, latched on capture
//   rrf_map            committed map; read only on the capture edge
//   flush_out          one-cycle flush of ROB/RS/LSQ/fetch queue
//   fl_clear           one-cycle free-list reset to empty
//   rat_load           one-cycle RAT load strobe
//   rat_restore_map    snapshot contents
//   fl_enq/_preg       free-list enqueue request and register index
//   fl_ready           free list accepts the enqueue this cycle
//   redirect_valid     fetch redirect, held until redirect_ready
//   redirect_pc/order  latched PC and order
//   redirect_ready     fetch accepts the redirect
//   stall_dispatch     high in every state except IDLE
//   rebuild_err        sticky: enqueue count differed from NUM_PHYS_REG-NUM_ARCH_REG
// -----------------------------------------------------------------------------
module mispredict_recovery_ctrl #(
  parameter int NUM_PHYS_REG = 64,
  parameter int NUM_ARCH_REG = 32,
  parameter int PREG_W       = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 mispredict_in,
  input  logic [31:0]                          mispredict_pc,
  input  logic [63:0]                          mispredict_order,
  input  logic [NUM_ARCH_REG-1:0][PREG_W-1:0]  rrf_map,
  output logic                                 flush_out,
  output logic                                 rat_load,
  output logic [NUM_ARCH_REG-1:0][PREG_W-1:0]  rat_restore_map,
  output logic                                 fl_clear,
  output logic                                 fl_enq,
  output logic [PREG_W-1:0]                    fl_enq_preg,
  input  logic                                 fl_ready,
  output logic                                 redirect_valid,
  output logic [31:0]                          redirect_pc,
  output logic [63:0]                          redirect_order,
  input  logic                                 redirect_ready,
  output logic                                 stall_dispatch,
  output logic                                 rebuild_err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_RESTORE  = 3'd2,
    ST_REBUILD  = 3'd3,
    ST_REDIRECT = 3'd4
  } state_e;

  // Walk terminates on an explicit compare, never on index overflow.
  localparam logic [PREG_W-1:0] IDX_LAST = PREG_W'(NUM_PHYS_REG - 1);
  // Count is one bit wider than the index so a full walk cannot wrap it.
  localparam logic [PREG_W:0]   EXP_CNT  = (PREG_W+1)'(NUM_PHYS_REG - NUM_ARCH_REG);

  state_e                                state_q, state_d;
  logic [NUM_ARCH_REG-1:0][PREG_W-1:0]   snap_q, snap_d;
  logic [NUM_PHYS_REG-1:0]               used_q, used_d;
  logic [31:0]                           pc_q, pc_d;
  logic [63:0]                           order_q, order_d;
  logic [PREG_W-1:0]                     idx_q, idx_d;
  logic [PREG_W:0]                       cnt_q, cnt_d;
  logic                                  err_q, err_d;

  logic [NUM_PHYS_REG-1:0]               used_cap_s;
  logic                                  adv_s;

  // Occupancy vector of the live committed map, latched only on capture.
  always_comb begin
    used_cap_s = '0;
    for (int i = 0; i < NUM_ARCH_REG; i++) begin
      used_cap_s[rrf_map[i]] = 1'b1;
    end
  end

  // State register and sequence datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      used_q  <= '0;
      pc_q    <= 32'd0;
      order_q <= 64'd0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      used_q  <= used_d;
      pc_q    <= pc_d;
      order_q <= order_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    used_d  = used_q;
    pc_d    = pc_q;
    order_d = order_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    adv_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mispredict_in) begin
          snap_d  = rrf_map;
          used_d  = used_cap_s;
          pc_d    = mispredict_pc;
          order_d = mispredict_order;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        state_d = ST_RESTORE;
      end

      ST_RESTORE: begin
        state_d = ST_REBUILD;
      end

      ST_REBUILD: begin
        // Mapped registers are skipped; free ones wait for the free list.
        if (used_q[idx_q]) begin
          adv_s = 1'b1;
        end else if (fl_ready) begin
          adv_s = 1'b1;
          cnt_d = cnt_q + (PREG_W+1)'(1);
        end else begin
          adv_s = 1'b0;
        end

        if (adv_s) begin
          if (idx_q == IDX_LAST) begin
            // cnt_d already includes an enqueue accepted on this last slot.
            err_d   = (cnt_d != EXP_CNT);
            state_d = ST_REDIRECT;
          end else begin
            idx_d = idx_q + PREG_W'(1);
          end
        end else begin
          state_d = ST_REBUILD;
        end
      end

      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REDIRECT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only; fl_ready never reaches them.
  assign flush_out       = (state_q == ST_FLUSH);
  assign fl_clear        = (state_q == ST_FLUSH);
  assign rat_load        = (state_q == ST_RESTORE);
  assign rat_restore_map = snap_q;
  assign fl_enq          = (state_q == ST_REBUILD) && !used_q[idx_q];
  assign fl_enq_preg     = fl_enq ? idx_q : '0;
  assign redirect_valid  = (state_q == ST_REDIRECT);
  assign redirect_pc     = pc_q;
  assign redirect_order  = order_q;
  assign stall_dispatch  = (state_q != ST_IDLE);
  assign rebuild_err     = err_q;

endmodule

// File: tb/tb_mispredict_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mispredict_recovery_ctrl
//
// Purpose:
//   Self-checking bench for mispredict_recovery_ctrl. Expected free-list
//   enqueues are pushed to a scoreboard queue when a mispredict is driven and
//   popped by a negedge monitor as the DUT hands them off.
// -----------------------------------------------------------------------------
module tb_mispredict_recovery_ctrl;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int PW = 6;

  logic                      clk;
  logic                      rst;
  logic                      mispredict_in;
  logic [31:0]               mispredict_pc;
  logic [63:0]               mispredict_order;
  logic [NA-1:0][PW-1:0]     rrf_map;
  logic                      flush_out;
  logic                      rat_load;
  logic [NA-1:0][PW-1:0]     rat_restore_map;
  logic                      fl_clear;
  logic                      fl_enq;
  logic [PW-1:0]             fl_enq_preg;
  logic                      fl_ready;
  logic                      redirect_valid;
  logic [31:0]               redirect_pc;
  logic [63:0]               redirect_order;
  logic                      redirect_ready;
  logic                      stall_dispatch;
  logic                      rebuild_err;

  mispredict_recovery_ctrl #(
    .NUM_PHYS_REG (NP),
    .NUM_ARCH_REG (NA),
    .PREG_W       (PW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mispredict_in    (mispredict_in),
    .mispredict_pc    (mispredict_pc),
    .mispredict_order (mispredict_order),
    .rrf_map          (rrf_map),
    .flush_out        (flush_out),
    .rat_load         (rat_load),
    .rat_restore_map  (rat_restore_map),
    .fl_clear         (fl_clear),
    .fl_enq           (fl_enq),
    .fl_enq_preg      (fl_enq_preg),
    .fl_ready         (fl_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_order   (redirect_order),
    .redirect_ready   (redirect_ready),
    .stall_dispatch   (stall_dispatch),
    .rebuild_err      (rebuild_err)
  );

  int                    n_checks = 0;
  int                    n_errors = 0;
  int                    sb_q[$];
  int                    enq_seen = 0;
  bit                    tog_en = 1'b0;
  bit                    hold_pend = 1'b0;
  logic [PW-1:0]         hold_preg = '0;
  logic [31:0]           exp_pc;
  logic [63:0]           exp_order;
  logic [NA-1:0][PW-1:0] id_map;
  logic [NA-1:0][PW-1:0] sc_map;
  logic [NA-1:0][PW-1:0] dup_map;
  logic [NA-1:0][PW-1:0] rev_map;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_flush"}, flush_out, 0);
    chk_eq({tag, "_flclr"}, fl_clear, 0);
    chk_eq({tag, "_ratld"}, rat_load, 0);
    chk_eq({tag, "_map"}, rat_restore_map, 0);
    chk_eq({tag, "_enq"}, fl_enq, 0);
    chk_eq({tag, "_enqp"}, fl_enq_preg, 0);
    chk_eq({tag, "_rv"}, redirect_valid, 0);
    chk_eq({tag, "_rpc"}, redirect_pc, 0);
    chk_eq({tag, "_rord"}, redirect_order, 0);
    chk_eq({tag, "_stall"}, stall_dispatch, 0);
    chk_eq({tag, "_err"}, rebuild_err, 0);
  endtask

  // fl_ready either held high or toggled every cycle.
  initial begin
    fl_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) fl_ready = ~fl_ready;
      else        fl_ready = 1'b1;
    end
  end

  // Enqueue monitor: pops the scoreboard on each accepted enqueue and
  // verifies a stalled enqueue holds its register.
  always @(negedge clk) begin
    int exp_p;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk_eq("hold_valid", fl_enq, 1);
        chk_eq("hold_preg", fl_enq_preg, hold_preg);
      end
      if (fl_enq && fl_ready) begin
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 255;
        chk_eq("enq_preg", fl_enq_preg, exp_p);
        enq_seen++;
      end
      hold_pend = fl_enq && !fl_ready;
      hold_preg = fl_enq_preg;
    end
  end

  // Drive a mispredict captured on the next edge; post_map replaces rrf_map
  // right after capture. Returns at the negedge of cycle 2 (RESTORE).
  task automatic start_seq(input logic [NA-1:0][PW-1:0] map,
                           input logic [NA-1:0][PW-1:0] post_map,
                           input logic [31:0] pc, input logic [63:0] ord);
    logic [NP-1:0] u;
    u = '0;
    for (int i = 0; i < NA; i++) u[map[i]] = 1'b1;
    sb_q.delete();
    for (int p = 0; p < NP; p++) if (!u[p]) sb_q.push_back(p);
    enq_seen  = 0;
    exp_pc    = pc;
    exp_order = ord;
    rrf_map          = map;
    mispredict_pc    = pc;
    mispredict_order = ord;
    mispredict_in    = 1'b1;
    @(posedge clk);
    #1;
    mispredict_in    = 1'b0;
    rrf_map          = post_map;
    mispredict_pc    = 32'hDEAD_BEEF;
    mispredict_order = 64'hFFFF;
    @(negedge clk);
    chk_eq("c1_flush", flush_out, 1);
    chk_eq("c1_flclr", fl_clear, 1);
    chk_eq("c1_ratld", rat_load, 0);
    chk_eq("c1_stall", stall_dispatch, 1);
    chk_eq("c1_err_clr", rebuild_err, 0);
    @(negedge clk);
    chk_eq("c2_ratld", rat_load, 1);
    chk_eq("c2_flush", flush_out, 0);
    chk_eq("c2_map", rat_restore_map, map);
  endtask

  // Wait for the redirect and finish the handshake; exp_n = negedges counted
  // from the caller's position until redirect_valid (0 = skip timing check).
  task automatic finish_seq(input logic exp_err, input int exp_n, input int hold_n,
                            input int exp_enqs);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (n < 400 && !seen) begin
      @(negedge clk);
      n++;
      seen = redirect_valid;
    end
    chk_eq("redirect_seen", seen, 1);
    if (exp_n > 0) chk_eq("redirect_cycle", n, exp_n);
    chk_eq("redirect_pc", redirect_pc, exp_pc);
    chk_eq("redirect_order", redirect_order, exp_order);
    chk_eq("rebuild_err", rebuild_err, exp_err);
    chk_eq("enq_count", enq_seen, exp_enqs);
    chk_eq("sb_empty", sb_q.size(), 0);
    for (int k = 0; k < hold_n; k++) begin
      chk_eq("rhold_valid", redirect_valid, 1);
      chk_eq("rhold_pc", redirect_pc, exp_pc);
      chk_eq("rhold_order", redirect_order, exp_order);
      chk_eq("rhold_stall", stall_dispatch, 1);
      @(posedge clk);
      #1;
      if (k == hold_n - 1) redirect_ready = 1'b1;
      if (k < hold_n - 1) @(negedge clk);
    end
    if (hold_n > 0) begin
      @(negedge clk);
      chk_eq("rhs_valid", redirect_valid, 1);
    end
    @(negedge clk);
    chk_eq("idle_stall", stall_dispatch, 0);
    chk_eq("idle_rv", redirect_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NA; i++) begin
      id_map[i]  = PW'(i);
      rev_map[i] = PW'(63 - i);
    end
    sc_map     = id_map;
    sc_map[5]  = 6'd40;
    sc_map[9]  = 6'd63;
    dup_map    = id_map;
    dup_map[3] = 6'd4;

    rst              = 1'b1;
    mispredict_in    = 1'b0;
    mispredict_pc    = 32'h0;
    mispredict_order = 64'h0;
    rrf_map          = id_map;
    redirect_ready   = 1'b1;
    #2;
    chk_all_zero("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Identity map, both readies high: exact cycle timing.
    start_seq(id_map, id_map, 32'h1000_0040, 64'd17);
    finish_seq(1'b0, 65, 0, 32);

    // Scattered map with fl_ready toggling.
    tog_en = 1'b1;
    start_seq(sc_map, sc_map, 32'h2000_0100, 64'd99);
    finish_seq(1'b0, 0, 0, 32);
    tog_en = 1'b0;

    // Duplicate mapping: one extra free register, sticky error.
    start_seq(dup_map, dup_map, 32'h3000_0000, 64'd5);
    finish_seq(1'b1, 65, 0, 33);
    chk_eq("err_sticky", rebuild_err, 1);

    // Clean mispredict clears the error; redirect held off five cycles.
    redirect_ready = 1'b0;
    start_seq(id_map, id_map, 32'h4000_0044, 64'h1_0000_0001);
    finish_seq(1'b0, 65, 5, 32);

    // Mispredict pulse mid-REBUILD and rrf_map changed after capture.
    start_seq(sc_map, rev_map, 32'h5000_0008, 64'd321);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    mispredict_in = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mispredict_in = 1'b0;
    finish_seq(1'b0, 53, 0, 32);
    chk_eq("snap_hold", rat_restore_map, sc_map);

    // Asynchronous reset mid-REBUILD, then a full sequence from idx 0.
    start_seq(id_map, id_map, 32'h6000_0000, 64'd7);
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("arst");
    sb_q.delete();
    @(posedge clk);
    #1;
    chk_all_zero("arst_hold");
    rst = 1'b0;
    rrf_map = id_map;
    start_seq(sc_map, sc_map, 32'h7000_0010, 64'd42);
    finish_seq(1'b0, 65, 0, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
